// File: rtl/brick_field_ctrl.sv
// Falling-brick field sequencer: round-robin collision scan, periodic descent, win/over detection.
// Optional macro BRICK_SPEEDUP_EN raises the descent step as the score grows.
module brick_field_ctrl #(
    parameter int NUM_BRICKS = 8,
    parameter int TICK_DIV   = 50000000,
    parameter int STEP       = 1,
    parameter int X0         = 8,
    parameter int X_PITCH    = 62,
    parameter int Y0         = 0,
    parameter int BRICK_W    = 57,
    parameter int BRICK_H    = 19,
    parameter int BALL_SZ    = 20,
    parameter int FLOOR_Y    = 458
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [8:0] ball_x,
    input  logic [8:0] ball_y,
    input  logic [2:0] rd_idx,
    output logic [8:0] rd_x,
    output logic [8:0] rd_y,
    output logic       rd_exist,
    output logic [7:0] alive_mask,
    output logic       hit,
    output logic [2:0] hit_idx,
    output logic [7:0] score,
    output logic       game_over,
    output logic       won
);
    localparam int MAX_SLOTS = 8;

    typedef enum logic [2:0] {IDLE, SCAN, CHECK, OVER, WON} state_t;

    state_t      state, state_nxt;
    logic [2:0]  k;
    logic [31:0] prescaler;
    logic        tick_pending;
    logic        over_flag;
    logic [7:0]  alive;
    logic [8:0]  y_q [MAX_SLOTS];

    logic        playing, restart, tick, last_slot, advance;
    logic        overlap, scan_hit, scan_floor;
    logic [8:0]  cur_x, cur_y;
    logic [10:0] bx11, by11, x11, y11;
    logic [8:0]  eff_step;

    // Slot x never changes after load, so it is derived from the index instead of stored.
    function automatic logic [8:0] slot_x(input logic [2:0] i);
        int v;
        v = X0 + int'(i) * X_PITCH;
        return v[8:0];
    endfunction

    function automatic logic [8:0] sat_add(input logic [8:0] a, input logic [8:0] b);
        logic [9:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[9] ? 9'h1FF : s[8:0];
    endfunction

    always_comb begin
        playing   = (state == SCAN) || (state == CHECK);
        restart   = start && ((state == IDLE) || (state == OVER) || (state == WON));
        tick      = playing && (prescaler == 32'(TICK_DIV - 1));
        last_slot = (k == 3'(NUM_BRICKS - 1));
        advance   = (state == CHECK) && !over_flag && (alive != 8'h00);
    end

    // Overlap is evaluated 11 bits wide so edge sums never wrap.
    always_comb begin
        cur_x   = slot_x(k);
        cur_y   = y_q[k];
        bx11    = {2'b00, ball_x};
        by11    = {2'b00, ball_y};
        x11     = {2'b00, cur_x};
        y11     = {2'b00, cur_y};
        overlap = (bx11 <= x11 + 11'(BRICK_W)) && (bx11 + 11'(BALL_SZ) >= x11) &&
                  (by11 <= y11 + 11'(BRICK_H)) && (by11 + 11'(BALL_SZ) >= y11);
        scan_hit   = (state == SCAN) && alive[k] && overlap;
        scan_floor = (state == SCAN) && alive[k] && !overlap && (cur_y >= 9'(FLOOR_Y));
    end

`ifdef BRICK_SPEEDUP_EN
    logic [7:0] score_div8;
    logic [1:0] bonus;
    always_comb begin
        score_div8 = score >> 3;
        bonus      = (score_div8 > 8'd3) ? 2'd3 : score_div8[1:0];
        eff_step   = 9'(STEP) + {7'b0, bonus};
    end
`else
    always_comb begin
        eff_step = 9'(STEP);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = SCAN;
            SCAN:  if (last_slot) state_nxt = CHECK;
            CHECK: begin
                if (over_flag)             state_nxt = OVER;
                else if (alive == 8'h00)   state_nxt = WON;
                else                       state_nxt = SCAN;
            end
            OVER:  if (start) state_nxt = SCAN;
            WON:   if (start) state_nxt = SCAN;
            default: state_nxt = IDLE;
        endcase
    end

    // Slot storage: load, clear on hit, or descend at CHECK.
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            for (int i = 0; i < MAX_SLOTS; i++) begin
                y_q[i]   <= 9'(Y0);
                alive[i] <= (i < NUM_BRICKS);
            end
        end else if (scan_hit) begin
            alive[k] <= 1'b0;
        end else if (advance && tick_pending) begin
            for (int i = 0; i < MAX_SLOTS; i++) begin
                if (alive[i]) y_q[i] <= sat_add(y_q[i], eff_step);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            score        <= 8'd0;
            hit          <= 1'b0;
            hit_idx      <= 3'd0;
            prescaler    <= 32'd0;
            tick_pending <= 1'b0;
            over_flag    <= 1'b0;
            k            <= 3'd0;
        end else begin
            hit <= scan_hit;
            if (scan_hit) hit_idx <= k;
            prescaler <= (tick || !playing) ? 32'd0 : prescaler + 32'd1;
            if (restart) begin
                score        <= 8'd0;
                over_flag    <= 1'b0;
                tick_pending <= 1'b0;
                k            <= 3'd0;
            end else begin
                // A fresh tick re-arms pending even in the cycle that consumes it.
                if (tick)         tick_pending <= 1'b1;
                else if (advance) tick_pending <= 1'b0;
                if (state == SCAN) begin
                    if (scan_hit) begin
                        if (score != 8'hFF) score <= score + 8'd1;
                    end else if (scan_floor) begin
                        over_flag <= 1'b1;
                    end
                    k <= last_slot ? 3'd0 : k + 3'd1;
                end else if (advance) begin
                    over_flag <= 1'b0;
                    k         <= 3'd0;
                end
            end
        end
    end

    always_comb begin
        rd_x       = slot_x(rd_idx);
        rd_y       = y_q[rd_idx];
        rd_exist   = alive[rd_idx];
        alive_mask = alive;
        game_over  = (state == OVER);
        won        = (state == WON);
    end

endmodule

// File: tb/tb_brick_field_ctrl.sv
// Randomized bench for brick_field_ctrl: cycle-level reference model plus a hit scoreboard
// drained by an independent monitor.
module tb_brick_field_ctrl;
    localparam int NB     = 8;
    localparam int TD     = 4;
    localparam int STEP_P = 1;
    localparam int X0_P   = 8;
    localparam int XP     = 62;
    localparam int Y0_P   = 0;
    localparam int BW     = 57;
    localparam int BH     = 19;
    localparam int BS     = 20;
    localparam int FY     = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [8:0] ball_x = 9'd0;
    logic [8:0] ball_y = 9'd0;
    logic [2:0] rd_idx = 3'd0;
    logic [8:0] rd_x, rd_y;
    logic       rd_exist;
    logic [7:0] alive_mask;
    logic       hit;
    logic [2:0] hit_idx;
    logic [7:0] score;
    logic       game_over, won;

    brick_field_ctrl #(
        .NUM_BRICKS(NB), .TICK_DIV(TD), .STEP(STEP_P), .X0(X0_P), .X_PITCH(XP),
        .Y0(Y0_P), .BRICK_W(BW), .BRICK_H(BH), .BALL_SZ(BS), .FLOOR_Y(FY)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .ball_x(ball_x), .ball_y(ball_y),
        .rd_idx(rd_idx), .rd_x(rd_x), .rd_y(rd_y), .rd_exist(rd_exist),
        .alive_mask(alive_mask), .hit(hit), .hit_idx(hit_idx), .score(score),
        .game_over(game_over), .won(won)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [10:0] exp_q[$];
    logic [10:0] mon_e;

    // Reference model: game mode (0 idle, 1 playing, 2 over, 3 won) and round position (NB = check).
    int m_mode = 0, m_pos = 0, m_presc = 0, m_score = 0, m_hit_idx = 0;
    bit m_pend = 0, m_ovf = 0, m_hit = 0;
    bit m_alive[NB];
    int m_y[NB];

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_load();
        for (int i = 0; i < NB; i++) begin
            m_alive[i] = 1'b1;
            m_y[i] = Y0_P;
        end
    endtask

    function automatic bit touches(int bx, int by, int x, int y);
        return (bx <= x + BW) && (bx + BS >= x) && (by <= y + BH) && (by + BS >= y);
    endfunction

    function automatic int step_now();
        int s = STEP_P;
`ifdef BRICK_SPEEDUP_EN
        s = s + (((m_score / 8) > 3) ? 3 : (m_score / 8));
`endif
        return s;
    endfunction

    task automatic model_cycle(input bit r, input bit st, input int bx, input int by);
        bit tick, consumed, any_alive;
        int s;
        m_hit = 1'b0;
        if (r) begin
            model_load();
            m_mode = 0; m_pos = 0; m_presc = 0; m_pend = 0; m_ovf = 0;
            m_score = 0; m_hit_idx = 0;
            return;
        end
        if (m_mode != 1) begin
            m_presc = 0;
            if (st) begin
                model_load();
                m_score = 0; m_ovf = 0; m_pend = 0; m_pos = 0; m_mode = 1;
            end
            return;
        end
        consumed = 1'b0;
        tick = (m_presc == TD - 1);
        m_presc = tick ? 0 : m_presc + 1;
        if (m_pos < NB) begin
            if (m_alive[m_pos] && touches(bx, by, X0_P + m_pos * XP, m_y[m_pos])) begin
                m_alive[m_pos] = 1'b0;
                m_hit = 1'b1;
                m_hit_idx = m_pos;
                if (m_score < 255) m_score++;
                exp_q.push_back({3'(m_pos), 8'(m_score)});
            end else if (m_alive[m_pos] && m_y[m_pos] >= FY) begin
                m_ovf = 1'b1;
            end
            m_pos++;
        end else begin
            any_alive = 1'b0;
            foreach (m_alive[i]) if (m_alive[i]) any_alive = 1'b1;
            if (m_ovf) m_mode = 2;
            else if (!any_alive) m_mode = 3;
            else begin
                s = step_now();
                if (m_pend)
                    foreach (m_y[i]) if (m_alive[i]) m_y[i] = (m_y[i] + s > 511) ? 511 : m_y[i] + s;
                consumed = 1'b1;
                m_pos = 0;
                m_ovf = 1'b0;
            end
        end
        if (tick) m_pend = 1'b1;
        else if (consumed) m_pend = 1'b0;
    endtask

    // One clock: drive at the falling edge, predict, then compare just after the rising edge.
    task automatic step_cycle(input bit r, input bit st, input int bx, input int by);
        int idx, mask;
        idx = $urandom_range(0, 7);
        rst = r; start = st; ball_x = 9'(bx); ball_y = 9'(by); rd_idx = 3'(idx);
        model_cycle(r, st, bx, by);
        @(posedge clk);
        #1;
        mask = 0;
        for (int i = 0; i < NB; i++) if (m_alive[i]) mask |= (1 << i);
        chk("alive_mask", int'(alive_mask), mask);
        chk("score", int'(score), m_score);
        chk("game_over", int'(game_over), (m_mode == 2) ? 1 : 0);
        chk("won", int'(won), (m_mode == 3) ? 1 : 0);
        chk("hit", int'(hit), int'(m_hit));
        chk("rd_x", int'(rd_x), X0_P + idx * XP);
        chk("rd_y", int'(rd_y), m_y[idx]);
        chk("rd_exist", int'(rd_exist), int'(m_alive[idx]));
        @(negedge clk);
    endtask

    task automatic pick_ball(input int kind, output int bx, output int by);
        int j;
        if (kind == 0) begin
            bx = 500; by = 300;
        end else if (kind == 1) begin
            j = (m_mode == 1 && m_pos < NB) ? m_pos : $urandom_range(0, NB - 1);
            bx = X0_P + j * XP + $urandom_range(0, BW);
            by = m_y[j] + $urandom_range(0, BH);
            if (bx > 511) bx = 511;
            if (by > 511) by = 511;
        end else begin
            bx = $urandom_range(0, 511); by = $urandom_range(0, 511);
        end
    endtask

    always @(negedge clk) begin
        if (hit === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL hit_unexpected: got hit_idx %0d expected no hit at %0t", hit_idx, $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("hit_idx", int'(hit_idx), int'(mon_e[10:8]));
                chk("hit_score", int'(score), int'(mon_e[7:0]));
            end
        end
    end

    initial begin
        int bx, by, kind, guard;
        @(negedge clk);
        repeat (3) step_cycle(1, 0, 0, 0);

        // Idle with the ball sitting on a brick: nothing may happen without start.
        repeat (50) step_cycle(0, 0, 200, 5);

        // Ball parked on slot 3: exactly one hit, never repeated.
        step_cycle(0, 1, 200, 5);
        repeat (40) step_cycle(0, 0, 200, 5);

        // Reset in the middle of a scan.
        step_cycle(1, 0, 0, 0);
        step_cycle(0, 1, 500, 300);
        guard = 0;
        while (m_pos != 4 && guard < 20) begin
            step_cycle(0, 0, 500, 300);
            guard++;
        end
        chk("reach_slot4", m_pos, 4);
        step_cycle(1, 0, 500, 300);
        step_cycle(0, 0, 500, 300);

        for (int g = 0; g < 12; g++) begin
            step_cycle(0, 1, 500, 300);
            guard = 0;
            while (m_mode == 1 && guard < 600) begin
                if (g % 3 == 0) kind = 0;
                else if (g % 3 == 1) kind = ($urandom_range(0, 3) == 0) ? 2 : 1;
                else kind = $urandom_range(0, 2);
                pick_ball(kind, bx, by);
                step_cycle(($urandom_range(0, 399) == 0), ($urandom_range(0, 15) == 0), bx, by);
                guard++;
            end
            repeat (5) begin
                pick_ball(2, bx, by);
                step_cycle(0, 0, bx, by);
            end
        end

        repeat (3) step_cycle(0, 0, 500, 300);
        chk("exp_q_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
